// File: rtl/lcd_ctrl_param.sv
// HD44780-style LCD controller: power-up wait, init sequence, then one host command per handshake (8- or 4-bit bus).
// Command busy for 1 accept cycle + 1 or 2 transfer phases; lcd_enable/init_req are ignored while busy=1.
module lcd_ctrl_param #(
  parameter int CLK_FREQ      = 360,
  parameter int CBITS         = 20,
  parameter int BUS4          = 0,
  parameter int POWERUP_US    = 500,
  parameter int XFER_US       = 50,
  parameter int EHIGH_US      = 13,
  parameter int CLEAR_WAIT_US = 200,
  parameter int ENTRY_WAIT_US = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] in_data,
  input  logic       init_req,
  input  logic       lcd_enable,
  input  logic [9:0] lcd_bus,
  output logic       busy,
  output logic       init_done,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic [7:0] lcd_data
);

  localparam int POW_LIM  = POWERUP_US * CLK_FREQ;
  localparam int XFER_LIM = XFER_US * CLK_FREQ;
  localparam int CLR_LIM  = CLEAR_WAIT_US * CLK_FREQ;
  localparam int ENT_LIM  = ENTRY_WAIT_US * CLK_FREQ;
  localparam int MAX_A    = (POWERUP_US > CLEAR_WAIT_US) ? POWERUP_US : CLEAR_WAIT_US;
  localparam int MAX_US   = (MAX_A > XFER_US) ? MAX_A : XFER_US;
  localparam int MAX_LIM  = MAX_US * CLK_FREQ;

  if (CLK_FREQ < 1 || longint'(MAX_LIM) >= (longint'(1) << CBITS)) begin : g_bad_params
    $error("lcd_ctrl_param: CBITS too narrow for the configured delays, or CLK_FREQ < 1");
  end

  localparam logic [CBITS-1:0] POW_END  = CBITS'(POW_LIM - 1);
  localparam logic [CBITS-1:0] XFER_END = CBITS'(XFER_LIM - 1);
  localparam logic [CBITS-1:0] CLR_END  = CBITS'(CLR_LIM - 1);
  localparam logic [CBITS-1:0] ENT_END  = CBITS'(ENT_LIM - 1);
  localparam logic [CBITS-1:0] E_ON     = CBITS'(CLK_FREQ);
  localparam logic [CBITS-1:0] E_OFF    = CBITS'((1 + EHIGH_US) * CLK_FREQ);
  localparam logic             IS8      = (BUS4 == 0);
  // Init command index: 0 = 4-bit wake-up phase (8'h20), 1 fn set, 2 display, 3 clear, 4 entry mode
  localparam logic [2:0]       IDX0     = IS8 ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_INIT    = 3'd1,
    S_IDLE    = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic             half, half_n;
  logic [6:0]       cfg, cfg_n;
  logic [9:0]       cmd, cmd_n;
  logic             done_n;

  logic             phase_end, wait_end, two_phase;
  logic             busy_d, e_d, rs_d, rw_d, split_d;
  logic [7:0]       data_d, byte_d;

  function automatic logic [7:0] init_byte(input logic [2:0] i, input logic [6:0] c);
    logic [7:0] b;
    case (i)
      3'd1:    b = {3'b001, IS8, c[6], c[5], 2'b00};
      3'd2:    b = {5'b00001, c[4:2]};
      3'd3:    b = 8'h01;
      3'd4:    b = {6'b000001, c[1:0]};
      default: b = 8'h20;
    endcase
    return b;
  endfunction

  assign phase_end = (cnt == XFER_END);
  assign wait_end  = (cnt == ((idx == 3'd3) ? CLR_END : ENT_END));
  assign two_phase = !IS8 && !(state == S_INIT && idx == 3'd0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    half_n  = half;
    cfg_n   = cfg;
    cmd_n   = cmd;
    done_n  = init_done;
    case (state)
      S_POWERUP: begin
        if (cnt == POW_END) begin
          state_n = S_INIT;
          cnt_n   = '0;
          idx_n   = IDX0;
          half_n  = 1'b0;
          cfg_n   = in_data;
        end
      end
      S_INIT, S_SEND: begin
        if (phase_end) begin
          cnt_n = '0;
          if (two_phase && !half) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (state == S_SEND)   state_n = S_IDLE;
            else if (idx >= 3'd3)  state_n = S_WAIT;
            else                   idx_n   = idx + 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (wait_end) begin
          cnt_n = '0;
          if (idx == 3'd3) begin
            state_n = S_INIT;
            idx_n   = 3'd4;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      S_IDLE: begin
        cnt_n = '0;
        // init_req wins; a simultaneous command is dropped and retried by the host
        if (init_req) begin
          state_n = S_INIT;
          idx_n   = IDX0;
          half_n  = 1'b0;
          cfg_n   = in_data;
          done_n  = 1'b0;
        end else if (lcd_enable) begin
          state_n = S_SEND;
          half_n  = 1'b0;
          cmd_n   = lcd_bus;
        end
      end
      default: begin
        state_n = S_POWERUP;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state register
  always_comb begin
    busy_d  = (state_n != S_IDLE);
    e_d     = 1'b0;
    rs_d    = 1'b0;
    rw_d    = 1'b0;
    data_d  = 8'h00;
    byte_d  = 8'h00;
    split_d = 1'b0;
    if (state_n == S_INIT || state_n == S_SEND) begin
      e_d     = (cnt_n >= E_ON) && (cnt_n < E_OFF);
      byte_d  = (state_n == S_SEND) ? cmd_n[7:0] : init_byte(idx_n, cfg_n);
      split_d = !IS8 && !(state_n == S_INIT && idx_n == 3'd0);
      if (!split_d)   data_d = byte_d;
      else if (half_n) data_d = {byte_d[3:0], 4'h0};
      else            data_d = {byte_d[7:4], 4'h0};
      if (state_n == S_SEND) begin
        rs_d = cmd_n[9];
        rw_d = cmd_n[8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_POWERUP;
      cnt       <= '0;
      idx       <= 3'd0;
      half      <= 1'b0;
      cfg       <= 7'd0;
      cmd       <= 10'd0;
      init_done <= 1'b0;
      busy      <= 1'b1;
      e         <= 1'b0;
      rs        <= 1'b0;
      rw        <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      half      <= half_n;
      cfg       <= cfg_n;
      cmd       <= cmd_n;
      init_done <= done_n;
      busy      <= busy_d;
      e         <= e_d;
      rs        <= rs_d;
      rw        <= rw_d;
      lcd_data  <= data_d;
    end
  end

  a_busy_idle: assert property (@(posedge clk) disable iff (!rst_n) busy == (state != S_IDLE));

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: 8-bit instance first, then the 4-bit instance (CLK_FREQ=2, POWERUP_US=10).
module tb_lcd_ctrl_param;

  logic       clk = 1'b0;
  logic       rst8_n, rst4_n, sel4;
  logic [6:0] in_data;
  logic       init_req, lcd_enable;
  logic [9:0] lcd_bus;

  logic       busy8, done8, e8, rs8, rw8;
  logic [7:0] d8;
  logic       busy4, done4, e4, rs4, rw4;
  logic [7:0] d4;

  logic       busy_m, done_m, e_m, rs_m, rw_m;
  logic [7:0] dat_m;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] p_dat [16];
  logic       p_rs  [16];
  logic       p_rw  [16];
  int         p_w   [16];
  int         p_t   [16];
  int         np, n_idle, early_done;
  logic [7:0] x_dat [16];

  always #5 clk = ~clk;

  lcd_ctrl_param #(.CLK_FREQ(2), .CBITS(20), .BUS4(0), .POWERUP_US(10), .XFER_US(50),
                   .EHIGH_US(13), .CLEAR_WAIT_US(200), .ENTRY_WAIT_US(100)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_data(in_data), .init_req(init_req),
    .lcd_enable(lcd_enable), .lcd_bus(lcd_bus), .busy(busy8), .init_done(done8),
    .e(e8), .rs(rs8), .rw(rw8), .lcd_data(d8));

  lcd_ctrl_param #(.CLK_FREQ(2), .CBITS(20), .BUS4(1), .POWERUP_US(10), .XFER_US(50),
                   .EHIGH_US(13), .CLEAR_WAIT_US(200), .ENTRY_WAIT_US(100)) u4 (
    .clk(clk), .rst_n(rst4_n), .in_data(in_data), .init_req(init_req),
    .lcd_enable(lcd_enable), .lcd_bus(lcd_bus), .busy(busy4), .init_done(done4),
    .e(e4), .rs(rs4), .rw(rw4), .lcd_data(d4));

  assign busy_m = sel4 ? busy4 : busy8;
  assign done_m = sel4 ? done4 : done8;
  assign e_m    = sel4 ? e4    : e8;
  assign rs_m   = sel4 ? rs4   : rs8;
  assign rw_m   = sel4 ? rw4   : rw8;
  assign dat_m  = sel4 ? d4    : d8;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps until busy drops, logging every e pulse (data/rs/rw at the rising edge, width, rise cycle)
  task automatic collect(input int start);
    int   n;
    logic pe;
    n = start; np = 0; pe = 1'b0; n_idle = -1; early_done = 0;
    while (n_idle < 0 && n < 3000) begin
      tick();
      n++;
      if (e_m && !pe && np < 16) begin
        p_dat[np] = dat_m; p_rs[np] = rs_m; p_rw[np] = rw_m; p_t[np] = n; p_w[np] = 0;
      end
      if (e_m && np < 16) p_w[np]++;
      if (!e_m && pe && np < 16) np++;
      pe = e_m;
      if (busy_m && done_m) early_done++;
      if (!busy_m) n_idle = n;
    end
  endtask

  task automatic check_pulses(input string tag, input int cnt, input logic rs_x);
    check_val({tag, "_count"}, np, cnt);
    for (int i = 0; i < cnt && i < np; i++) begin
      check_val($sformatf("%s_dat%0d", tag, i), p_dat[i], x_dat[i]);
      check_val($sformatf("%s_w%0d", tag, i), p_w[i], 26);
      check_val($sformatf("%s_rs%0d", tag, i), p_rs[i], rs_x);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst8_n = 1'b0; rst4_n = 1'b0; sel4 = 1'b0;
    in_data = 7'b1111110; init_req = 1'b0; lcd_enable = 1'b0; lcd_bus = 10'h000;
    repeat (3) tick();

    check_val("rst_busy", busy_m, 1);
    check_val("rst_done", done_m, 0);
    check_val("rst_e", e_m, 0);
    check_val("rst_rs", rs_m, 0);
    check_val("rst_rw", rw_m, 0);
    check_val("rst_data", dat_m, 8'h00);

    // Power-up then 8-bit init
    rst8_n = 1'b1;
    collect(0);
    x_dat[0] = 8'h3C; x_dat[1] = 8'h0F; x_dat[2] = 8'h01; x_dat[3] = 8'h06;
    check_pulses("t1", 4, 1'b0);
    check_val("t1_first_rise", p_t[0], 22);
    check_val("t1_clear_rise", p_t[2], 222);
    check_val("t1_entry_rise", p_t[3], 722);
    check_val("t1_idle_cycle", n_idle, 1020);
    check_val("t1_init_done", done_m, 1);
    check_val("t1_early_done", early_done, 0);

    // Single command
    lcd_bus = 10'h241; lcd_enable = 1'b1;
    tick();
    lcd_enable = 1'b0;
    check_val("t2_busy", busy_m, 1);
    check_val("t2_rs", rs_m, 1);
    check_val("t2_rw", rw_m, 0);
    check_val("t2_data", dat_m, 8'h41);
    check_val("t2_e_setup", e_m, 0);
    collect(1);
    x_dat[0] = 8'h41;
    check_pulses("t2", 1, 1'b1);
    check_val("t2_rise", p_t[0], 3);
    check_val("t2_idle_cycle", n_idle, 101);
    repeat (3) tick();
    check_val("t2_stay_idle", busy_m, 0);

    // Enable held through SEND with a changing bus
    lcd_bus = 10'h241; lcd_enable = 1'b1;
    tick();
    lcd_bus = 10'h155;
    collect(1);
    check_pulses("t4a", 1, 1'b1);
    check_val("t4_idle_cycle", n_idle, 101);
    tick();
    check_val("t4_second_busy", busy_m, 1);
    check_val("t4_second_rs", rs_m, 0);
    check_val("t4_second_rw", rw_m, 1);
    check_val("t4_second_data", dat_m, 8'h55);
    lcd_enable = 1'b0;
    collect(1);
    x_dat[0] = 8'h55;
    check_pulses("t4b", 1, 1'b0);
    check_val("t4b_rw", p_rw[0], 1);
    check_val("t4b_idle_cycle", n_idle, 101);

    // Re-init with a simultaneous command; in_data changes after sampling
    in_data = 7'b0010011; init_req = 1'b1; lcd_enable = 1'b1; lcd_bus = 10'h2AA;
    tick();
    init_req = 1'b0; lcd_enable = 1'b0; in_data = 7'b1111111;
    check_val("t5_done_clr", done_m, 0);
    check_val("t5_busy", busy_m, 1);
    check_val("t5_rs", rs_m, 0);
    collect(1);
    x_dat[0] = 8'h30; x_dat[1] = 8'h0C; x_dat[2] = 8'h01; x_dat[3] = 8'h07;
    check_pulses("t5", 4, 1'b0);
    check_val("t5_first_rise", p_t[0], 3);
    check_val("t5_idle_cycle", n_idle, 1001);
    check_val("t5_init_done", done_m, 1);

    // Async reset while e is high
    in_data = 7'b1111110;
    lcd_bus = 10'h241; lcd_enable = 1'b1;
    tick();
    lcd_enable = 1'b0;
    for (int k = 0; k < 50 && !e_m; k++) tick();
    check_val("t6_e_high", e_m, 1);
    #2;
    rst8_n = 1'b0;
    #1;
    check_val("t6_e", e_m, 0);
    check_val("t6_rs", rs_m, 0);
    check_val("t6_rw", rw_m, 0);
    check_val("t6_data", dat_m, 8'h00);
    check_val("t6_busy", busy_m, 1);
    check_val("t6_done", done_m, 0);
    @(posedge clk);
    #1;
    rst8_n = 1'b1;
    collect(0);
    check_val("t6_first_rise", p_t[0], 22);
    check_val("t6_count", np, 4);
    check_val("t6_idle_cycle", n_idle, 1020);

    // 4-bit instance: init with wake-up phase, then a split command
    sel4 = 1'b1;
    tick();
    rst4_n = 1'b1;
    collect(0);
    x_dat[0] = 8'h20; x_dat[1] = 8'h20; x_dat[2] = 8'hC0; x_dat[3] = 8'h00; x_dat[4] = 8'hF0;
    x_dat[5] = 8'h00; x_dat[6] = 8'h10; x_dat[7] = 8'h00; x_dat[8] = 8'h60;
    check_pulses("t3i", 9, 1'b0);
    check_val("t3i_fs_rise", p_t[1], 122);
    check_val("t3i_entry_rise", p_t[7], 1122);
    check_val("t3i_idle_cycle", n_idle, 1520);
    check_val("t3i_init_done", done_m, 1);

    lcd_bus = 10'h241; lcd_enable = 1'b1;
    tick();
    lcd_enable = 1'b0;
    check_val("t3_busy", busy_m, 1);
    check_val("t3_data_hi", dat_m, 8'h40);
    collect(1);
    x_dat[0] = 8'h40; x_dat[1] = 8'h10;
    check_pulses("t3", 2, 1'b1);
    check_val("t3_rise0", p_t[0], 3);
    check_val("t3_rise1", p_t[1], 103);
    check_val("t3_idle_cycle", n_idle, 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
